// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs one MIPS instruction request per handshake into the 32-bit machine
// word understood by the single-cycle `ctrl` decoder. Each word is written
// into instruction memory at an auto-incrementing word pointer. The `li`
// pseudo-instruction expands into a lui/ori pair that occupies two
// consecutive write cycles.
//
// Ports
//   clk        : the only clock; all state changes on the rising edge
//   reset      : synchronous, active-high; overrides every other input
//   req_valid  : a request is present
//   req_ready  : a request can be accepted this cycle (depends on state only)
//   req_kind   : 0 R, 1 ori, 2 lui, 3 lw, 4 sw, 5 beq, 6 j, 7 jal, 8 jr, 9 li
//                (codes 10..15 are illegal)
//   req_rs/rt/rd, req_func, req_imm : instruction fields
//   im_we      : instruction-memory write strobe (one cycle per word)
//   im_addr    : word address of the write
//   im_wdata   : encoded instruction word
//   err        : one-cycle pulse after an illegal kind has been accepted
//   wrapped    : sticky, set once the pointer has wrapped past the top word
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [5:0]        req_func,
    input  logic [31:0]       req_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              err,
    output logic              wrapped
);

    typedef enum logic {
        ST_RUN,
        ST_LI2
    } state_t;

    localparam logic [3:0] K_R   = 4'd0;
    localparam logic [3:0] K_ORI = 4'd1;
    localparam logic [3:0] K_LUI = 4'd2;
    localparam logic [3:0] K_LW  = 4'd3;
    localparam logic [3:0] K_SW  = 4'd4;
    localparam logic [3:0] K_BEQ = 4'd5;
    localparam logic [3:0] K_J   = 4'd6;
    localparam logic [3:0] K_JAL = 4'd7;
    localparam logic [3:0] K_JR  = 4'd8;
    localparam logic [3:0] K_LI  = 4'd9;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wrap_pend;
    logic              r_wrapped;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [4:0]        r_li_rt;
    logic [15:0]       r_li_lo;

    logic              w_legal;
    logic [31:0]       w_word;
    logic [31:0]       w_li_ori;
    logic              w_emit;
    logic [31:0]       w_emit_word;
    logic              w_err_next;
    logic              w_latch_li;

    // Encoding of the request currently on the input; for li this is the lui half.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_word  = '0;
        w_legal = 1'b1;
        case (req_kind)
            K_R: begin
                // R-type carrying the jr function code is emitted in the jr form.
                if (req_func == FN_JR) w_word = {OP_SPECIAL, req_rs, 15'b0, FN_JR};
                else                   w_word = {OP_SPECIAL, req_rs, req_rt, req_rd, 5'b0, req_func};
            end
            K_ORI:   w_word = {OP_ORI, req_rs, req_rt, req_imm[15:0]};
            K_LUI:   w_word = {OP_LUI, 5'b0, req_rt, req_imm[15:0]};
            K_LW:    w_word = {OP_LW, req_rs, req_rt, req_imm[15:0]};
            K_SW:    w_word = {OP_SW, req_rs, req_rt, req_imm[15:0]};
            K_BEQ:   w_word = {OP_BEQ, req_rs, req_rt, req_imm[15:0]};
            K_J:     w_word = {OP_J, req_imm[27:2]};
            K_JAL:   w_word = {OP_JAL, req_imm[27:2]};
            K_JR:    w_word = {OP_SPECIAL, req_rs, 15'b0, FN_JR};
            K_LI:    w_word = {OP_LUI, 5'b0, req_rt, req_imm[31:16]};
            default: w_legal = 1'b0;
        endcase
    end

    // Second half of li, rebuilt from the fields latched at acceptance.
    assign w_li_ori = {OP_ORI, r_li_rt, r_li_rt, r_li_lo};

    // Next-state and emit decisions.
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_emit_word  = w_word;
        w_err_next   = 1'b0;
        w_latch_li   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (req_valid) begin
                    if (!w_legal) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_emit = 1'b1;
                        if (req_kind == K_LI) begin
                            w_latch_li   = 1'b1;
                            w_state_next = ST_LI2;
                        end
                    end
                end
            end
            ST_LI2: begin
                w_emit       = 1'b1;
                w_emit_word  = w_li_ori;
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            r_state     <= ST_RUN;
            r_ptr       <= '0;
            r_wrap_pend <= 1'b0;
            r_wrapped   <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state <= w_state_next;
            r_we    <= w_emit;
            r_err   <= w_err_next;
            // A word leaving from the top address wraps the pointer; the sticky
            // flag follows one cycle later, alongside the first word at 0.
            r_wrap_pend <= w_emit && (r_ptr == '1);
            r_wrapped   <= r_wrapped | r_wrap_pend;
            if (w_emit) begin
                r_addr  <= r_ptr;
                r_wdata <= w_emit_word;
                r_ptr   <= r_ptr + ADDR_W'(1);
            end
        end
    end

    // NOTE: the li payload has no reset; it is only read in ST_LI2, which is
    // entered solely through the same edge that loads it.
    always_ff @(posedge clk) begin
        if (w_latch_li) begin
            r_li_rt <= req_rt;
            r_li_lo <= req_imm[15:0];
        end
    end

    assign req_ready = (r_state == ST_RUN);
    assign im_we     = r_we;
    assign im_addr   = r_addr;
    assign im_wdata  = r_wdata;
    assign err       = r_err;
    assign wrapped   = r_wrapped;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Two encoder instances share all inputs: one with the default 1024-word
// address space and one with a 4-word space so pointer wrap is reachable.
// A word-level reference model (a count of words written since reset, a
// pending second li word and the expected output registers) predicts every
// output after each clock edge. Directed steps follow the documented
// examples, then randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic [3:0]  req_kind;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [5:0]  req_func;
    logic [31:0] req_imm;

    logic        req_ready,  im_we,  err,  wrapped;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        req_ready2, im_we2, err2, wrapped2;
    logic [1:0]  im_addr2;
    logic [31:0] im_wdata2;

    instr_encoder #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_func(req_func), .req_imm(req_imm), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .err(err), .wrapped(wrapped)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
        .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_func(req_func), .req_imm(req_imm), .im_we(im_we2), .im_addr(im_addr2),
        .im_wdata(im_wdata2), .err(err2), .wrapped(wrapped2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit          m_pend;       // second li word still to be written
    logic [31:0] m_pend_word;
    int          m_count;      // words written since reset
    bit          e_we, e_err, e_wrap1, e_wrap2;
    int          e_idx;        // sequence number of the last word presented
    logic [31:0] e_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Machine word from the field rules, built with shifts and arithmetic.
    function automatic logic [31:0] enc_first(input logic [3:0] k, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [4:0] rd,
                                              input logic [5:0] fn, input logic [31:0] imm);
        logic [31:0] lo16, hi16, tgt, s, t, d;
        lo16 = imm % 32'd65536;
        hi16 = imm / 32'd65536;
        tgt  = (imm / 32'd4) % 32'd67108864;
        s    = 32'(rs) << 21;
        t    = 32'(rt) << 16;
        d    = 32'(rd) << 11;
        case (k)
            4'd0:    return (fn == 6'd8) ? (s | 32'd8) : (s | t | d | 32'(fn));
            4'd1:    return (32'd13 << 26) | s | t | lo16;
            4'd2:    return (32'd15 << 26) | t | lo16;
            4'd3:    return (32'd35 << 26) | s | t | lo16;
            4'd4:    return (32'd43 << 26) | s | t | lo16;
            4'd5:    return (32'd4  << 26) | s | t | lo16;
            4'd6:    return (32'd2  << 26) | tgt;
            4'd7:    return (32'd3  << 26) | tgt;
            4'd8:    return s | 32'd8;
            default: return (32'd15 << 26) | t | hi16;   // li: lui half
        endcase
    endfunction

    function automatic logic [31:0] enc_li_ori(input logic [4:0] rt, input logic [31:0] imm);
        return (32'd13 << 26) | (32'(rt) << 21) | (32'(rt) << 16) | (imm % 32'd65536);
    endfunction

    // Advance the model by one clock edge using the inputs that edge sampled.
    task automatic model_edge(input logic rst, input logic v, input logic [3:0] k,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [5:0] fn, input logic [31:0] imm);
        if (rst) begin
            m_pend  = 0;
            m_count = 0;
            e_we    = 0;
            e_err   = 0;
            e_wrap1 = 0;
            e_wrap2 = 0;
            e_idx   = 0;
            e_wdata = '0;
        end else begin
            // The flag rises the cycle after the top-address word was presented.
            if (e_we && (e_idx % 1024) == 1023) e_wrap1 = 1;
            if (e_we && (e_idx % 4) == 3)       e_wrap2 = 1;
            e_we  = 0;
            e_err = 0;
            if (m_pend) begin
                e_we    = 1;
                e_idx   = m_count;
                e_wdata = m_pend_word;
                m_count++;
                m_pend  = 0;
            end else if (v) begin
                if (k > 4'd9) begin
                    e_err = 1;
                end else begin
                    e_we    = 1;
                    e_idx   = m_count;
                    e_wdata = enc_first(k, rs, rt, rd, fn, imm);
                    m_count++;
                    if (k == 4'd9) begin
                        m_pend      = 1;
                        m_pend_word = enc_li_ori(rt, imm);
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("ready",    32'(req_ready),  32'(!m_pend));
        check("we",       32'(im_we),      32'(e_we));
        check("err",      32'(err),        32'(e_err));
        check("wrapped",  32'(wrapped),    32'(e_wrap1));
        check("addr",     32'(im_addr),    32'(e_idx % 1024));
        check("wdata",    im_wdata,        e_wdata);
        check("ready2",   32'(req_ready2), 32'(!m_pend));
        check("we2",      32'(im_we2),     32'(e_we));
        check("err2",     32'(err2),       32'(e_err));
        check("wrapped2", 32'(wrapped2),   32'(e_wrap2));
        check("addr2",    32'(im_addr2),   32'(e_idx % 4));
        check("wdata2",   im_wdata2,       e_wdata);
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare just after it.
    task automatic step(input logic rst, input logic v, input logic [3:0] k,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [5:0] fn, input logic [31:0] imm);
        reset     = rst;
        req_valid = v;
        req_kind  = k;
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_func  = fn;
        req_imm   = imm;
        @(posedge clk);
        model_edge(rst, v, k, rs, rt, rd, fn, imm);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0);
    endtask

    task automatic req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn, input logic [31:0] imm);
        step(1'b0, 1'b1, k, rs, rt, rd, fn, imm);
    endtask

    initial begin
        // Reset state.
        do_reset();
        do_reset();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_we",    32'(im_we),     32'd0);
        check("rst_wdata", im_wdata,       32'd0);

        // ori, addu back-to-back, jr, and R-type carrying the jr function.
        req(4'd1, 5'd0, 5'd8, 5'd0, 6'd0, 32'h0000_1234);
        check("ori_addr", 32'(im_addr), 32'd0);
        check("ori_data", im_wdata, 32'h3408_1234);
        req(4'd0, 5'd9, 5'd10, 5'd8, 6'h21, 32'hFFFF_FFFF);
        check("addu_we",   32'(im_we), 32'd1);
        check("addu_addr", 32'(im_addr), 32'd1);
        check("addu_data", im_wdata, 32'h012A_4021);
        req(4'd8, 5'd31, 5'd7, 5'd7, 6'h3F, 32'h1234_5678);
        check("jr_data", im_wdata, 32'h03E0_0008);
        req(4'd0, 5'd31, 5'd5, 5'd6, 6'h08, 32'd0);
        check("rjr_data", im_wdata, 32'h03E0_0008);
        idle();
        check("idle_we", 32'(im_we), 32'd0);
        check("idle_hold", im_wdata, 32'h03E0_0008);

        // li from pointer 0 with a follow-on request held valid throughout.
        do_reset();
        req(4'd9, 5'd0, 5'd8, 5'd0, 6'd0, 32'hDEAD_BEEF);
        check("lui_addr",  32'(im_addr), 32'd0);
        check("lui_data",  im_wdata, 32'h3C08_DEAD);
        check("lui_ready", 32'(req_ready), 32'd0);
        req(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 32'd5);
        check("lio_addr",  32'(im_addr), 32'd1);
        check("lio_data",  im_wdata, 32'h3508_BEEF);
        check("lio_ready", 32'(req_ready), 32'd1);
        req(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 32'd5);
        check("held_addr", 32'(im_addr), 32'd2);
        check("held_data", im_wdata, 32'h3422_0005);
        idle();

        // Branches and jumps.
        req(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 32'h0000_FFFF);
        check("beq_data", im_wdata, 32'h1022_FFFF);
        req(4'd7, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0000_3008);
        check("jal_data", im_wdata, 32'h0C00_0C02);
        req(4'd3, 5'd0, 5'd9, 5'd0, 6'd0, 32'd4);
        check("lw_data", im_wdata, 32'h8C09_0004);

        // Illegal kind at pointer 5.
        do_reset();
        for (int i = 0; i < 5; i++) req(4'd4, 5'(i), 5'd3, 5'd0, 6'd0, 32'(i * 4));
        req(4'd15, 5'd1, 5'd1, 5'd1, 6'd1, 32'd1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_we",  32'(im_we), 32'd0);
        req(4'd6, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0040_0000);
        check("ill_next_addr", 32'(im_addr), 32'd5);
        check("ill_err_drop",  32'(err), 32'd0);

        // li straddling the wrap in the 4-word instance.
        do_reset();
        for (int i = 0; i < 3; i++) req(4'd2, 5'd0, 5'(i), 5'd0, 6'd0, 32'(i));
        req(4'd9, 5'd0, 5'd3, 5'd0, 6'd0, 32'h1234_5678);
        check("wrap_lui_addr", 32'(im_addr2), 32'd3);
        check("wrap_lui_flag", 32'(wrapped2), 32'd0);
        idle();
        check("wrap_ori_addr", 32'(im_addr2), 32'd0);
        check("wrap_ori_data", im_wdata2, 32'h3463_5678);
        check("wrap_ori_flag", 32'(wrapped2), 32'd1);
        idle();
        check("wrap_sticky", 32'(wrapped2), 32'd1);
        do_reset();
        check("wrap_cleared", 32'(wrapped2), 32'd0);

        // Reset during the LI2 cycle discards the ori half.
        req(4'd9, 5'd0, 5'd4, 5'd0, 6'd0, 32'hCAFE_F00D);
        step(1'b1, 1'b1, 4'd1, 5'd2, 5'd3, 5'd0, 6'd0, 32'd7);
        check("li2rst_we",    32'(im_we), 32'd0);
        check("li2rst_ready", 32'(req_ready), 32'd1);
        req(4'd1, 5'd2, 5'd3, 5'd0, 6'd0, 32'd7);
        check("li2rst_addr", 32'(im_addr), 32'd0);
        check("li2rst_data", im_wdata, 32'h3443_0007);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] k;
            logic [5:0] fn;
            k  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            fn = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
            step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0), k,
                 5'($urandom), 5'($urandom), 5'($urandom), fn, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader: the encoding counterpart of the single-cycle `ctrl` decoder. It accepts one instruction request per handshake as a kind code plus register, function and immediate fields, and packs it into the 32-bit machine word that `ctrl` decodes. It writes that word into the instruction memory through a write port, using an auto-incrementing word pointer. It sits in front of the P4 CPU's instruction memory and is used by test harnesses and boot loaders to fill program images. It also expands the `li` pseudo-instruction into a two-word `lui`/`ori` sequence.

## Interface
Parameters:
- `ADDR_W`, default 10: width of the instruction-memory word address (1024 words).

Ports:
- `clk` in 1: the only clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; overrides every other input.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_kind` in 4: instruction kind. 0 R-type, 1 ori, 2 lui, 3 lw, 4 sw, 5 beq, 6 j, 7 jal, 8 jr, 9 li. Codes 10–15 are illegal.
- `req_rs` in 5, `req_rt` in 5, `req_rd` in 5: register fields.
- `req_func` in 6: function field, used for R-type only.
- `req_imm` in 32: immediate, branch offset, jump target byte address, or the full `li` constant.
- `im_we` out 1: instruction-memory write strobe.
- `im_addr` out ADDR_W: word address of the write.
- `im_wdata` out 32: encoded instruction word.
- `err` out 1: one-cycle pulse on an illegal kind.
- `wrapped` out 1: sticky flag, set when the pointer wraps.

## Operation
- A request is accepted on a cycle where `req_valid && req_ready`.
- Encodings use `imm16 = req_imm[15:0]`:
  - R-type: {000000, rs, rt, rd, 00000, func}. If func is 001000, the word is encoded as jr.
  - jr: {000000, rs, 15'b0, 001000}.
  - ori: {001101, rs, rt, imm16}.
  - lui: {001111, 00000, rt, imm16}.
  - lw: {100011, rs, rt, imm16}.
  - sw: {101011, rs, rt, imm16}.
  - beq: {000100, rs, rt, imm16}.
  - j: {000010, req_imm[27:2]}.
  - jal: {000011, req_imm[27:2]}.
  - li: word 1 is lui rt, req_imm[31:16]; word 2 is {001101, rt, rt, req_imm[15:0]}.
- Unused fields of the input are ignored; unused fields of the output word are zero.
- Internal word pointer `ptr` (ADDR_W bits):
  - Each emitted word is written at `ptr`, after which `ptr` increments.
  - The pointer wraps from 2^ADDR_W−1 to 0 and sets `wrapped`.
  - `wrapped` stays set until reset.
- State machine, two states:
  - RUN: `req_ready`=1.
    - Legal non-li request accepted: emit one word next cycle, stay in RUN.
    - li accepted: emit the lui word next cycle, latch rt and imm low half, go to LI2.
    - Illegal kind accepted: no write, `err`=1 next cycle, `ptr` unchanged, stay in RUN.
  - LI2: `req_ready`=0. Emit the ori word at the incremented pointer next cycle and return to RUN.
- Reset in any state, including mid-li:
  - Pending li half is discarded.
  - State returns to RUN.
  - `ptr`=0, `wrapped`=0.
  - A request presented in the reset cycle is not accepted.

## Timing
- All outputs are registered.
- Reset values:
  - `im_we`=0, `im_addr`=0, `im_wdata`=0, `err`=0, `wrapped`=0.
  - `req_ready`=1 on the first cycle after reset.
- Latency: the word appears with `im_we`=1 exactly one cycle after acceptance. `im_we`/`err` are high for one cycle per event; when `im_we`=0, `im_addr`/`im_wdata` hold their last values.
- Throughput: one word per cycle.
  - Back-to-back non-li requests produce consecutive writes with no bubble.
  - li occupies two write cycles. `req_ready` is low during the cycle in which the lui word is presented, and high again during the cycle in which the ori word is presented. A request accepted then writes on the following cycle, back-to-back with the ori word.
- `req_ready` is a combinational function of the state only, never of `req_valid`.
- li straddling the wrap: lui is written at 2^ADDR_W−1, ori at 0, and `wrapped` rises in the same cycle the ori write is issued.

## Test plan
- ori, addu and jr:
  - kind=1, rs=0, rt=8, imm=0x1234 → next cycle `im_we`=1, addr 0, data 0x34081234.
  - Then kind=0, rs=9, rt=10, rd=8, func=0x21 → addr 1, data 0x012A4021. No gap between the two writes.
  - kind=8, rs=31 → data 0x03E00008.
- li: kind=9, rt=8, imm=0xDEADBEEF at ptr 0 → addr 0 gets 0x3C08DEAD with `req_ready`=0 that cycle, then addr 1 gets 0x3508BEEF. A request held valid throughout is accepted in the ori cycle and written at addr 2.
- Branches and jumps:
  - beq rs=1, rt=2, imm=0xFFFF → 0x1022FFFF.
  - jal imm=0x00003008 → 0x0C000C02.
  - lw rs=0, rt=9, imm=4 → 0x8C090004.
- Illegal kind 15 at ptr 5 → `err`=1 for one cycle, `im_we`=0, next legal word written at addr 5.
- Wrap with ADDR_W=2: three single-word writes, then li → writes at 3 and 0, `wrapped`=1 from the ori write onward. A following reset clears it to 0.
- Reset asserted in the LI2 cycle → no ori write, `ptr`=0, `req_ready`=1 the cycle after reset deasserts, next word lands at addr 0.
